// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl
// Sequencer and accumulator for an 8x8 multiplier built from an external
// 4x4 multiplier and a partial-product shifter. Operands are captured on
// an accepted start. One nibble pair is issued per cycle over four cycles.
// The returned shifted partial products are summed into a 16-bit product.
// A one-cycle done pulse marks the cycle in which the product is valid.
//
// Handshake: start is a request that is accepted only when the block is
// idle (busy=0, done=0). No ready output exists, so a start raised while
// busy or done is dropped rather than queued. The caller sees completion
// as the single-cycle done pulse.
//
// Optional feature, enabled by defining SEQ_MULT_OVF_CHECK_EN:
// the accumulator is widened to 17 bits. A sticky err flag records any
// carry out of bit 15. With the macro undefined, err is tied low.

module seq_mult_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  dataa,
   input  logic [7:0]  datab,
   output logic [3:0]  mult_a,
   output logic [3:0]  mult_b,
   output logic [1:0]  shift_cntrl,
   input  logic [15:0] pp_in,
   output logic [15:0] product,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Shifter control encodings
   localparam logic [1:0] SHIFT_0 = 2'b00;
   localparam logic [1:0] SHIFT_4 = 2'b01;
   localparam logic [1:0] SHIFT_8 = 2'b10;

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [7:0]  a_q, a_d;
   logic [7:0]  b_q, b_d;
   logic [15:0] product_q, product_d;

`ifdef SEQ_MULT_OVF_CHECK_EN
   logic [16:0] acc_sum;
   logic        err_q, err_d;
`else
   logic [15:0] acc_sum;
`endif

   // Running sum of the accumulated product and the incoming partial product
   always_comb begin
`ifdef SEQ_MULT_OVF_CHECK_EN
      acc_sum = {1'b0, product_q} + {1'b0, pp_in};
`else
      acc_sum = product_q + pp_in;
`endif
   end

   // Next-state, operand capture and accumulation
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      a_d       = a_q;
      b_d       = b_q;
      product_d = product_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_CALC;
               cnt_d   = 2'd0;
               a_d     = dataa;
               b_d     = datab;
            end
         end
         ST_CALC: begin
            // The first step overwrites, so no stale result leaks into a new product
            if (cnt_q == 2'd0) begin
               product_d = pp_in;
            end else begin
               product_d = acc_sum[15:0];
            end
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

`ifdef SEQ_MULT_OVF_CHECK_EN
   // Sticky overflow flag: cleared by an accepted start, set by any carry out of bit 15
   always_comb begin
      err_d = err_q;
      if (state_q == ST_IDLE && start) begin
         err_d = 1'b0;
      end else if (state_q == ST_CALC && cnt_q != 2'd0 && acc_sum[16]) begin
         err_d = 1'b1;
      end
   end

   // Overflow flag register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   // State, step counter, operand and product registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 2'd0;
         a_q       <= 8'h00;
         b_q       <= 8'h00;
         product_q <= 16'h0000;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         a_q       <= a_d;
         b_q       <= b_d;
         product_q <= product_d;
      end
   end

   // Nibble and shift selection, decoded only from registered state and step count
   always_comb begin
      mult_a      = 4'h0;
      mult_b      = 4'h0;
      shift_cntrl = SHIFT_0;
      if (state_q == ST_CALC) begin
         mult_a = cnt_q[0] ? a_q[7:4] : a_q[3:0];
         mult_b = cnt_q[1] ? b_q[7:4] : b_q[3:0];
         case (cnt_q)
            2'd0:    shift_cntrl = SHIFT_0;
            2'd3:    shift_cntrl = SHIFT_8;
            default: shift_cntrl = SHIFT_4;
         endcase
      end
   end

   assign product = product_q;
   assign busy    = (state_q == ST_CALC);
   assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Testbench for seq_mult_ctrl. It models the external 4x4 multiplier and
// shifter behaviourally and checks every product against plain a*b.
// It checks the nibble schedule, the busy/done timing, the ignored restart,
// the held start, the asynchronous reset and the overflow flag.

module tb_seq_mult_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  dataa = 8'h00;
  logic [7:0]  datab = 8'h00;
  logic [3:0]  mult_a;
  logic [3:0]  mult_b;
  logic [1:0]  shift_cntrl;
  logic [15:0] pp_in;
  logic [15:0] product;
  logic        busy;
  logic        done;
  logic        err;
  logic        force_ff = 1'b0;

  int errors = 0;
  int checks = 0;

`ifdef SEQ_MULT_OVF_CHECK_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  // clock / reset
  always #5 clk = ~clk;

  seq_mult_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dataa(dataa), .datab(datab),
    .mult_a(mult_a), .mult_b(mult_b), .shift_cntrl(shift_cntrl), .pp_in(pp_in),
    .product(product), .busy(busy), .done(done), .err(err)
  );

  // external 4x4 multiplier followed by the shifter (00->0, 01->4, 10->8)
  always_comb begin
    pp_in = ({12'h000, mult_a} * {12'h000, mult_b}) << {shift_cntrl, 2'b00};
    if (force_ff) pp_in = 16'hFFFF;
  end

  // one full operation, with optional start re-pulse during the step before step rp+1
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int rp, input string tag);
    logic [15:0] exp_p;
    logic [3:0]  a_nib[4];
    logic [3:0]  b_nib[4];
    logic [1:0]  shf[4];
    exp_p = 16'(a) * 16'(b);
    a_nib = '{a[3:0], a[7:4], a[3:0], a[7:4]};
    b_nib = '{b[3:0], b[3:0], b[7:4], b[7:4]};
    shf   = '{2'b00, 2'b01, 2'b01, 2'b10};
    @(negedge clk);
    start = 1'b1; dataa = a; datab = b;
    @(posedge clk); #1;
    start = 1'b0; dataa = 8'($urandom); datab = 8'($urandom);
    for (int k = 0; k < 4; k++) begin
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy step%0d: got %b want 1", tag, k, busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s done step%0d: got %b want 0", tag, k, done); end
      checks++; if (mult_a !== a_nib[k]) begin errors++; $display("FAIL %s mult_a step%0d: got %h want %h", tag, k, mult_a, a_nib[k]); end
      checks++; if (mult_b !== b_nib[k]) begin errors++; $display("FAIL %s mult_b step%0d: got %h want %h", tag, k, mult_b, b_nib[k]); end
      checks++; if (shift_cntrl !== shf[k]) begin errors++; $display("FAIL %s shift step%0d: got %b want %b", tag, k, shift_cntrl, shf[k]); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL %s err step%0d: got %b want 0", tag, k, err); end
      if (k == rp) begin
        start = 1'b1; dataa = 8'($urandom); datab = ~b;
      end
      if (k == rp + 1) start = 1'b0;
      @(posedge clk); #1;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s done pulse: got %b want 1", tag, done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy in done: got %b want 0", tag, busy); end
    checks++; if (product !== exp_p) begin errors++; $display("FAIL %s product: got %h want %h", tag, product, exp_p); end
    checks++; if ({mult_a, mult_b, shift_cntrl} !== 10'h000) begin errors++; $display("FAIL %s idle drive in done: got %h want 000", tag, {mult_a, mult_b, shift_cntrl}); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s done after pulse: got %b want 0", tag, done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy in idle: got %b want 0", tag, busy); end
    checks++; if (product !== exp_p) begin errors++; $display("FAIL %s product hold: got %h want %h", tag, product, exp_p); end
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #3;
    checks++; if (product !== 16'h0000) begin errors++; $display("FAIL reset product: got %h want 0000", product); end
    checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL reset flags: got %b want 000", {busy, done, err}); end
    checks++; if ({mult_a, mult_b, shift_cntrl} !== 10'h000) begin errors++; $display("FAIL reset drive: got %h want 000", {mult_a, mult_b, shift_cntrl}); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_max;
    run_op(8'hFF, 8'hFF, -1, "max");
  endtask

  task automatic test_steps;
    run_op(8'h12, 8'h34, -1, "steps");
  endtask

  task automatic test_zero_after_max;
    run_op(8'hFF, 8'hFF, -1, "pre_zero");
    run_op(8'h00, 8'hAB, -1, "zero");
  endtask

  task automatic test_random;
    for (int i = 0; i < 12; i++)
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), -1, "random");
  endtask

  task automatic test_restart_ignored;
    run_op(8'h5C, 8'hE7, 1, "restart");
  endtask

  task automatic test_back_to_back;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp_p;
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    exp_p = 16'(a) * 16'(b);
    @(negedge clk);
    start = 1'b1; dataa = a; datab = b;
    for (int cyc = 0; cyc < 24; cyc++) begin
      @(posedge clk); #1;
      checks++; if (done !== (cyc % 6 == 4)) begin errors++; $display("FAIL held done cyc%0d: got %b want %b", cyc, done, (cyc % 6 == 4)); end
      checks++; if (busy !== (cyc % 6 < 4)) begin errors++; $display("FAIL held busy cyc%0d: got %b want %b", cyc, busy, (cyc % 6 < 4)); end
      if (cyc % 6 == 4) begin
        checks++; if (product !== exp_p) begin errors++; $display("FAIL held product cyc%0d: got %h want %h", cyc, product, exp_p); end
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held stop busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    start = 1'b1; dataa = 8'hC3; datab = 8'h9A;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst busy before: got %b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (product !== 16'h0000) begin errors++; $display("FAIL midrst product: got %h want 0000", product); end
    checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("FAIL midrst flags: got %b want 000", {busy, done, err}); end
    checks++; if ({mult_a, mult_b, shift_cntrl} !== 10'h000) begin errors++; $display("FAIL midrst drive: got %h want 000", {mult_a, mult_b, shift_cntrl}); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst done cyc%0d: got %b want 0", i, done); end
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL midrst after release: got %b want 00", {busy, done}); end
    run_op(8'hC3, 8'h9A, -1, "post_rst");
  endtask

  task automatic test_overflow;
    force_ff = 1'b1;
    @(negedge clk);
    start = 1'b1; dataa = 8'($urandom); datab = 8'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ovf err E0: got %b want 0", err); end
    @(posedge clk); #1;
    checks++; if (product !== 16'hFFFF) begin errors++; $display("FAIL ovf product E1: got %h want FFFF", product); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL ovf err E1: got %b want 0", err); end
    @(posedge clk); #1;
    checks++; if (err !== OVF_EN) begin errors++; $display("FAIL ovf err E2: got %b want %b", err, OVF_EN); end
    @(posedge clk); #1;
    checks++; if (err !== OVF_EN) begin errors++; $display("FAIL ovf err E3: got %b want %b", err, OVF_EN); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL ovf done: got %b want 1", done); end
    checks++; if (product !== 16'hFFFC) begin errors++; $display("FAIL ovf product: got %h want FFFC", product); end
    checks++; if (err !== OVF_EN) begin errors++; $display("FAIL ovf err E4: got %b want %b", err, OVF_EN); end
    @(posedge clk); #1;
    checks++; if (err !== OVF_EN) begin errors++; $display("FAIL ovf err after done: got %b want %b", err, OVF_EN); end
    force_ff = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (err !== OVF_EN) begin errors++; $display("FAIL ovf err sticky idle: got %b want %b", err, OVF_EN); end
    run_op(8'h77, 8'h3B, -1, "ovf_clear");
  endtask

  initial begin
    test_reset();
    test_max();
    test_steps();
    test_zero_after_max();
    test_random();
    test_restart_ignored();
    test_back_to_back();
    test_reset_mid();
    test_overflow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
